clkdiv_multi: RTL and testbench

- Parametrised, multi-channel successor to the fixed three-output divider.
- NUM_CH independent channels each divide the system clock by a runtime-programmable terminal count.
- Each channel provides a 50% duty toggling output and a one-cycle enable strobe. Downstream logic uses the strobe as a clock enable so it stays in the clk domain.
- Sits between the board clock/reset and the game FSM, display scan, blink and input-sampling logic. Adds per-channel enable, glitch-free divisor reload and a global phase-align clear.

---
 rtl/clkdiv_multi.sv | 96 +++++++++
 tb/tb_clkdiv_multi.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi.sv
// ---------------------------------------------------------------------------
// clkdiv_multi
//
// Multi-channel programmable clock divider. Each of NUM_CH channels counts
// enabled clk cycles up to its active terminal count, then wraps. On the wrap
// it raises a one-cycle tick strobe and toggles a 50% duty divided output.
// Downstream logic is expected to use tick as a clock enable, so that it
// stays in the clk domain.
//
// A new divisor presented on div_val is only adopted on a wrap, or by
// sync_clr. Because of this, a period in flight is never shortened or
// stretched. sync_clr also realigns the phase of every channel.
//
// Ports
//   clk       in   1             system clock, all logic on posedge
//   rst       in   1             asynchronous reset, active low
//   en        in   NUM_CH        per-channel run enable
//   div_val   in   NUM_CH*CNT_W  packed terminal counts, ch i at [i*CNT_W +: CNT_W]
//   sync_clr  in   1             synchronous clear / phase-align of all channels
//   div_out   out  NUM_CH        per-channel divided clock (registered)
//   tick      out  NUM_CH        per-channel one-cycle strobe (registered)
// ---------------------------------------------------------------------------
module clkdiv_multi #(
    parameter int          NUM_CH      = 3,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 200000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*CNT_W-1:0]   div_val,
    input  logic                      sync_clr,
    output logic [NUM_CH-1:0]         div_out,
    output logic [NUM_CH-1:0]         tick
);

    localparam logic [CNT_W-1:0] DEFAULT_TERM = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic [CNT_W-1:0]  cnt_q  [NUM_CH];
    logic [CNT_W-1:0]  cnt_d  [NUM_CH];
    logic [CNT_W-1:0]  term_q [NUM_CH];
    logic [CNT_W-1:0]  term_d [NUM_CH];
    logic [NUM_CH-1:0] div_q;
    logic [NUM_CH-1:0] div_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;

    // Per-channel next state. Priority is sync_clr, then en, then hold.
    // Equality against term is enough to stop cnt running past it: term is
    // only ever replaced at the moment cnt returns to zero.
    always_comb begin
        div_d  = div_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            term_d[i] = term_q[i];
            if (sync_clr) begin
                cnt_d[i]  = '0;
                term_d[i] = div_val[i*CNT_W +: CNT_W];
                div_d[i]  = 1'b0;
            end else if (en[i]) begin
                if (cnt_q[i] == term_q[i]) begin
                    cnt_d[i]  = '0;
                    term_d[i] = div_val[i*CNT_W +: CNT_W];
                    div_d[i]  = ~div_q[i];
                    tick_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                term_q[i] <= DEFAULT_TERM;
            end
            div_q  <= '0;
            tick_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                term_q[i] <= term_d[i];
            end
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign div_out = div_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
module tb_clkdiv_multi;

    localparam int NUM_CH      = 3;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       en = '0;
    logic [NUM_CH*CNT_W-1:0] div_val = {8'd4, 8'd4, 8'd4};
    logic                    sync_clr = 1'b0;
    logic [NUM_CH-1:0]       div_out;
    logic [NUM_CH-1:0]       tick;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles remaining until the next tick, counted down.
    int          rem [NUM_CH];
    logic [2:0]  mo;
    logic [2:0]  mt;

    clkdiv_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .sync_clr (sync_clr),
        .div_out  (div_out),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    function automatic int dv(input int i);
        return int'(div_val[i*CNT_W +: CNT_W]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) rem[i] = DEFAULT_DIV + 1;
        mo = '0;
        mt = '0;
    endtask

    // Advance one posedge, update the model from the inputs seen at that edge,
    // then move 1 time unit past the edge so outputs can be sampled.
    task automatic step();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                mt[i] = 1'b0;
                if (sync_clr) begin
                    rem[i] = dv(i) + 1;
                    mo[i]  = 1'b0;
                end else if (en[i]) begin
                    rem[i] = rem[i] - 1;
                    if (rem[i] == 0) begin
                        mt[i]  = 1'b1;
                        mo[i]  = ~mo[i];
                        rem[i] = dv(i) + 1;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        en = '0;
        sync_clr = 1'b0;
        div_val = {8'd4, 8'd4, 8'd4};
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] et, eo;
        model_reset();
        #2;
        n_tests++;
        if (div_out !== 3'b000 || tick !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_initial: div_out=%b tick=%b want 000 000", div_out, tick);
        end
        @(negedge clk);
        rst = 1'b1;
        en  = 3'b111;
        for (int k = 1; k <= 15; k++) begin
            step();
            et = (k % 5 == 0) ? 3'b111 : 3'b000;
            eo = ((k / 5) % 2 == 1) ? 3'b111 : 3'b000;
            n_tests++;
            if (tick !== et || div_out !== eo) begin
                n_fail++;
                $display("FAIL reset_first_period k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, eo, et);
            end
        end
        // Outputs are all high here; assert reset between edges.
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if (div_out !== 3'b000 || tick !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async_midrun: div_out=%b tick=%b want 000 000", div_out, tick);
        end
    endtask

    task automatic test_reload();
        logic et, eo;
        do_reset();
        en = 3'b111;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) div_val[7:0] = 8'd2;
            et = (k == 5 || k == 8 || k == 11 || k == 14);
            eo = (k >= 5 && k < 8) || (k >= 11 && k < 14);
            n_tests++;
            if (tick[0] !== et || div_out[0] !== eo) begin
                n_fail++;
                $display("FAIL reload_ch0 k=%0d: div_out0=%b tick0=%b want %b %b",
                         k, div_out[0], tick[0], eo, et);
            end
            n_tests++;
            if (tick !== mt || div_out !== mo) begin
                n_fail++;
                $display("FAIL reload_model k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, mo, mt);
            end
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 3'b111;
        step();
        step();
        en[1] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            n_tests++;
            if (tick[1] !== 1'b0 || div_out[1] !== 1'b0 || tick !== mt || div_out !== mo) begin
                n_fail++;
                $display("FAIL enable_frozen k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, mo, mt);
            end
        end
        en[1] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_tests++;
            if (tick[1] !== (k == 3) || div_out[1] !== (k == 3)) begin
                n_fail++;
                $display("FAIL enable_resume k=%0d: div_out1=%b tick1=%b want %b %b",
                         k, div_out[1], tick[1], (k == 3), (k == 3));
            end
        end
    endtask

    task automatic test_phase_align();
        logic [2:0] et, eo;
        do_reset();
        en = 3'b001;
        step();
        step();
        en = 3'b011;
        step();
        div_val  = {8'd9, 8'd4, 8'd4};
        sync_clr = 1'b1;
        en       = 3'b111;
        step();
        sync_clr = 1'b0;
        n_tests++;
        if (div_out !== 3'b000 || tick !== 3'b000) begin
            n_fail++;
            $display("FAIL phase_clear: div_out=%b tick=%b want 000 000", div_out, tick);
        end
        for (int k = 1; k <= 15; k++) begin
            if (k == 15) sync_clr = 1'b1;
            step();
            if (k == 15) begin
                et = 3'b000;
                eo = 3'b000;
            end else begin
                et[0] = (k % 5 == 0);
                et[1] = (k % 5 == 0);
                et[2] = (k == 10);
                eo[0] = ((k / 5) % 2 == 1);
                eo[1] = ((k / 5) % 2 == 1);
                eo[2] = (k >= 10);
            end
            n_tests++;
            if (tick !== et || div_out !== eo || tick !== mt || div_out !== mo) begin
                n_fail++;
                $display("FAIL phase_align k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, eo, et);
            end
        end
        sync_clr = 1'b0;
    endtask

    task automatic test_edge_divisors();
        do_reset();
        en = 3'b111;
        div_val[23:16] = 8'd0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_tests++;
            if (tick[2] !== 1'b1 || div_out[2] !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL edge_term0 k=%0d: div_out2=%b tick2=%b want %b 1",
                         k, div_out[2], tick[2], (k % 2 == 1));
            end
        end
        div_val[23:16] = 8'd255;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (tick[2] !== (k % 256 == 0) || div_out[2] !== ((k / 256) % 2 == 1)
                || tick !== mt || div_out !== mo) begin
                n_tests++;
                n_fail++;
                $display("FAIL edge_term255 k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, mo, mt);
            end else if (k % 64 == 0) begin
                n_tests++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            en = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0)
                div_val[$urandom_range(0, 2)*CNT_W +: CNT_W] = 8'($urandom_range(0, 6));
            sync_clr = ($urandom_range(0, 24) == 0);
            step();
            n_tests++;
            if (tick !== mt || div_out !== mo) begin
                n_fail++;
                $display("FAIL random k=%0d: div_out=%b tick=%b want %b %b",
                         k, div_out, tick, mo, mt);
            end
        end
        sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reload();
        test_enable();
        test_phase_align();
        test_edge_divisors();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
